// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if: request/acknowledge bus between a requester and dmem_responder.
//
// Signals
//   req    requester -> responder  held high until ack is seen
//   we     requester -> responder  1 = write, 0 = read, sampled with req
//   addr   requester -> responder  16-bit word address, sampled with req
//   wdata  requester -> responder  16-bit write data, sampled with req
//   ack    responder -> requester  one-cycle completion pulse
//   rdata  responder -> requester  read data, valid in the ack cycle and held
//   busy   responder -> requester  transaction in progress
//   err    responder -> requester  out-of-range flag, valid in the ack cycle
//
// Modports: master (requester side), slave (responder side).
// -----------------------------------------------------------------------------
interface dmem_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder: single-port 16-bit word memory behind a req/ack handshake
// with a programmable number of wait states before each acknowledge.
//
// Parameters
//   DEPTH        number of 16-bit words (power of two, 2..65536)
//   WAIT_CYCLES  wait states inserted before ack (0..15)
//
// Ports
//   clk    single clock, rising edge
//   reset  asynchronous active-low reset
//   bus    dmem_if.slave: req/we/addr/wdata in, ack/rdata/busy/err out
//
// Build option
//   DMEM_RANGE_CHK_EN  when defined, addresses >= DEPTH flag err in the ack
//                      cycle, suppress the write and read back 16'hFFFF.
//                      When undefined, err is tied low and addresses wrap
//                      modulo DEPTH.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Word address modulo DEPTH (DEPTH is a power of two, so truncation).
    function automatic logic [AW-1:0] word_index(input logic [15:0] a);
        word_index = AW'(a);
    endfunction

`ifdef DMEM_RANGE_CHK_EN
    // Compared at 17 bits so DEPTH = 65536 never flags.
    function automatic logic out_of_range(input logic [15:0] a);
        out_of_range = ({1'b0, a} >= 17'(DEPTH));
    endfunction
`endif

    logic [15:0] mem_r [DEPTH];

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [15:0] addr_r;
    logic [15:0] wdata_r;
    logic        ack_r;
    logic        busy_r;
    logic [15:0] rdata_r;
`ifdef DMEM_RANGE_CHK_EN
    logic        err_r;
`endif

    logic        txn_we_s;
    logic [15:0] txn_addr_s;
    logic        enter_ack_s;
    logic [15:0] rd_value_s;
    logic        commit_s;

    // With zero wait states ACK is entered straight from IDLE, so the
    // transaction fields come from the bus rather than the latches.
    always_comb begin
        txn_we_s   = we_r;
        txn_addr_s = addr_r;
        if (state_r == ST_IDLE) begin
            txn_we_s   = bus.we;
            txn_addr_s = bus.addr;
        end else begin
            txn_we_s   = we_r;
            txn_addr_s = addr_r;
        end
    end

    // Marks the edge on which the FSM moves into ACK.
    always_comb begin
        enter_ack_s = 1'b0;
        if (state_r == ST_IDLE) begin
            enter_ack_s = bus.req && (WAIT_CYCLES == 0);
        end else if (state_r == ST_WAIT) begin
            enter_ack_s = (cnt_r == 4'd0);
        end else begin
            enter_ack_s = 1'b0;
        end
    end

    // Read data that will be captured into rdata on entry to ACK.
    always_comb begin
        rd_value_s = mem_r[word_index(txn_addr_s)];
`ifdef DMEM_RANGE_CHK_EN
        if (out_of_range(txn_addr_s)) begin
            rd_value_s = 16'hFFFF;
        end else begin
            rd_value_s = mem_r[word_index(txn_addr_s)];
        end
`endif
    end

    // Writes land on the edge that ends the ACK cycle; a reset forces IDLE
    // asynchronously, so an aborted transaction never reaches this point.
`ifdef DMEM_RANGE_CHK_EN
    assign commit_s = (state_r == ST_ACK) && we_r && !err_r;
`else
    assign commit_s = (state_r == ST_ACK) && we_r;
`endif

    // Memory array: no reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[word_index(addr_r)] <= wdata_r;
        end
    end

    // Control FSM with registered ack/busy/rdata/err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
            rdata_r <= 16'h0000;
`ifdef DMEM_RANGE_CHK_EN
            err_r   <= 1'b0;
`endif
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req) begin
                        we_r    <= bus.we;
                        addr_r  <= bus.addr;
                        wdata_r <= bus.wdata;
                        busy_r  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_r <= ST_ACK;
                            ack_r   <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= 4'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= 4'd0;
                end
            endcase

            if (enter_ack_s && !txn_we_s) begin
                rdata_r <= rd_value_s;
            end
`ifdef DMEM_RANGE_CHK_EN
            err_r <= enter_ack_s ? out_of_range(txn_addr_s) : 1'b0;
`endif
        end
    end

    assign bus.ack   = ack_r;
    assign bus.busy  = busy_r;
    assign bus.rdata = rdata_r;
`ifdef DMEM_RANGE_CHK_EN
    assign bus.err   = err_r;
`else
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder: directed bench for dmem_responder. Two instances share
// clock and reset: index 1 uses WAIT_CYCLES=2, index 0 uses WAIT_CYCLES=0.
// Expected responses are queued when a request is issued; a monitor per
// instance pops and compares on every ack.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

`ifdef DMEM_RANGE_CHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;

    dmem_if bus0 ();
    dmem_if bus2 ();

    logic        req_v   [2];
    logic        we_v    [2];
    logic [15:0] addr_v  [2];
    logic [15:0] wdata_v [2];
    logic        ack_w   [2];
    logic        busy_w  [2];
    logic        err_w   [2];
    logic [15:0] rdata_w [2];

    assign bus0.req   = req_v[0];
    assign bus0.we    = we_v[0];
    assign bus0.addr  = addr_v[0];
    assign bus0.wdata = wdata_v[0];
    assign bus2.req   = req_v[1];
    assign bus2.we    = we_v[1];
    assign bus2.addr  = addr_v[1];
    assign bus2.wdata = wdata_v[1];

    assign ack_w[0]   = bus0.ack;
    assign busy_w[0]  = bus0.busy;
    assign err_w[0]   = bus0.err;
    assign rdata_w[0] = bus0.rdata;
    assign ack_w[1]   = bus2.ack;
    assign busy_w[1]  = bus2.busy;
    assign err_w[1]   = bus2.err;
    assign rdata_w[1] = bus2.rdata;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int          total = 0;
    int          bad   = 0;
    exp_t        q0 [$];
    exp_t        q2 [$];
    logic [15:0] last_rd [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the zero-wait instance.
    always @(negedge clk) begin
        exp_t e;
        if (ack_w[0] === 1'b1) begin
            if (q0.size() == 0) begin
                chk("ack0_unexpected", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("rdata0", 32'(rdata_w[0]), 32'(e.rdata));
                chk("err0", 32'(err_w[0]), 32'(e.err));
            end
        end
    end

    // Scoreboard monitor for the two-wait instance.
    always @(negedge clk) begin
        exp_t e;
        if (ack_w[1] === 1'b1) begin
            if (q2.size() == 0) begin
                chk("ack2_unexpected", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("rdata2", 32'(rdata_w[1]), 32'(e.rdata));
                chk("err2", 32'(err_w[1]), 32'(e.err));
            end
        end
    end

    // mode 0: plain, 1: change inputs during WAIT, 2: drop req during WAIT
    task automatic txn(input int inst, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] er,
                       input logic ee, input int mode);
        int   wc;
        int   n;
        int   busy_n;
        bit   got;
        exp_t e;
        wc = (inst == 0) ? 0 : 2;
        e.rdata = w ? last_rd[inst] : er;
        e.err   = ee;
        if (!w) last_rd[inst] = er;
        @(negedge clk);
        req_v[inst]   = 1'b1;
        we_v[inst]    = w;
        addr_v[inst]  = a;
        wdata_v[inst] = d;
        if (inst == 0) q0.push_back(e);
        else           q2.push_back(e);
        n = 0; busy_n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (busy_w[inst] === 1'b1) busy_n++;
            if (ack_w[inst] === 1'b1) begin
                got = 1;
                req_v[inst] = 1'b0;
            end else if (mode == 1) begin
                we_v[inst]    = ~w;
                addr_v[inst]  = 16'h0006;
                wdata_v[inst] = 16'h1234;
            end else if (mode == 2) begin
                req_v[inst] = 1'b0;
            end
        end
        req_v[inst] = 1'b0;
        chk($sformatf("latency%0d_%0h", inst, a), 32'(n), 32'(wc + 1));
        chk($sformatf("busy_cycles%0d_%0h", inst, a), 32'(busy_n), 32'(wc + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int m;
        exp_t e;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = 16'h0; wdata_v[i] = 16'h0;
            last_rd[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ack%0d", i), 32'(ack_w[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst_err%0d", i), 32'(err_w[i]), 32'd0);
            chk($sformatf("rst_rdata%0d", i), 32'(rdata_w[i]), 32'd0);
        end
        @(posedge clk);
        #2 reset = 1'b1;

        // Basic write then read, two wait states
        txn(1, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b0, 0);
        txn(1, 1'b0, 16'h0010, 16'h0,    16'hBEEF, 1'b0, 0);

        // Inputs changing after acceptance are ignored
        txn(1, 1'b1, 16'h0006, 16'h0606, 16'h0, 1'b0, 0);
        txn(1, 1'b1, 16'h0005, 16'hAAAA, 16'h0, 1'b0, 1);
        txn(1, 1'b0, 16'h0005, 16'h0,    16'hAAAA, 1'b0, 0);
        txn(1, 1'b0, 16'h0006, 16'h0,    16'h0606, 1'b0, 0);

        // Dropping req in WAIT still completes exactly once
        txn(1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 2);
        repeat (4) @(negedge clk);
        chk("drop_busy_idle", 32'(busy_w[1]), 32'd0);
        chk("drop_q_empty", 32'(q2.size()), 32'd0);

        // Address past DEPTH
        txn(1, 1'b1, 16'h0000, 16'h0000, 16'h0, 1'b0, 0);
        txn(1, 1'b1, 16'h0100, 16'h7777, 16'h0, RC, 0);
        txn(1, 1'b0, 16'h0100, 16'h0, RC ? 16'hFFFF : 16'h7777, RC, 0);
        txn(1, 1'b0, 16'h0000, 16'h0, RC ? 16'h0000 : 16'h7777, 1'b0, 0);

        // Reset during WAIT aborts the pending write
        txn(1, 1'b1, 16'h0007, 16'h1111, 16'h0, 1'b0, 0);
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'h0007; wdata_v[1] = 16'h5555;
        @(negedge clk);
        chk("pre_abort_busy", 32'(busy_w[1]), 32'd1);
        #1 reset = 1'b0;
        req_v[1] = 1'b0;
        #1;
        chk("abort_ack", 32'(ack_w[1]), 32'd0);
        chk("abort_busy", 32'(busy_w[1]), 32'd0);
        chk("abort_err", 32'(err_w[1]), 32'd0);
        chk("abort_rdata", 32'(rdata_w[1]), 32'd0);
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        txn(1, 1'b0, 16'h0007, 16'h0, 16'h1111, 1'b0, 0);

        // Zero wait states: back-to-back write then read with req held
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'h0001; wdata_v[0] = 16'h1234;
        e.rdata = last_rd[0]; e.err = 1'b0;
        q0.push_back(e);
        m = 0;
        while (ack_w[0] !== 1'b1 && m < 20) begin
            @(negedge clk);
            m++;
        end
        chk("b2b_first_latency", 32'(m), 32'd1);
        we_v[0] = 1'b0;
        e.rdata = 16'h1234; e.err = 1'b0;
        q0.push_back(e);
        last_rd[0] = 16'h1234;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (ack_w[0] !== 1'b1 && m < 20);
        req_v[0] = 1'b0;
        chk("b2b_ack_gap", 32'(m), 32'd2);
        txn(0, 1'b1, 16'h0002, 16'h4321, 16'h0, 1'b0, 0);
        txn(0, 1'b0, 16'h0002, 16'h0, 16'h4321, 1'b0, 0);

        repeat (5) @(negedge clk);
        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q2_empty", 32'(q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 16-bit words stored (power of two, 2..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before ack (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  requester holds high until it sees ack.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  16  word address; sampled with req.
REQ-008 SHALL have port wdata  input  16  write data; sampled with req.
REQ-009 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  16  read data; valid in ack cycle, held until next read ack.
REQ-011 SHALL have port busy  output  1  high while a transaction is in progress (WAIT or ACK state).
REQ-012 SHALL have port err  output  1  out-of-range flag, valid in ack cycle (see Configuration).

Function
REQ-013 SHALL implement FSM with states IDLE, WAIT, ACK.
REQ-014 IDLE: req=1 at a rising edge SHALL latch we/addr/wdata and go to WAIT (WAIT_CYCLES>0) or ACK (WAIT_CYCLES=0); req=0 stays IDLE.
REQ-015 WAIT: SHALL load a down-counter with WAIT_CYCLES-1 on entry, decrement each cycle, go to ACK on the edge where counter is 0.
REQ-016 ACK: ack SHALL be 1 for exactly one cycle, then FSM SHALL return to IDLE.
REQ-017 Latency: if req first sampled at edge k, ack SHALL be high in the cycle following edge k+WAIT_CYCLES.
REQ-018 Write SHALL commit latched wdata to mem[latched addr mod DEPTH] at the edge ending the ACK cycle.
REQ-019 Read SHALL load rdata from mem[latched addr mod DEPTH] at the edge entering ACK; rdata SHALL be unchanged by writes and idle cycles.
REQ-020 Inputs changing after acceptance SHALL NOT affect the transaction in progress.
REQ-021 req dropping during WAIT SHALL NOT abort; transaction completes and ack pulses.
REQ-022 Requester drops req in the ack cycle; req still high in the first IDLE cycle SHALL be accepted as a new transaction (back-to-back, one idle cycle between acks at WAIT_CYCLES=0).
REQ-023 Read of an address written in the previous transaction SHALL return the new data.
REQ-024 Memory contents SHALL power up undefined and SHALL NOT be cleared by reset.

Reset
REQ-025 reset=0 SHALL asynchronously force state IDLE, ack=0, busy=0, err=0, rdata=16'h0000, counter=0.
REQ-026 Reset asserted mid-transaction SHALL abort it: no ack, pending write not committed.
REQ-027 First request SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-028 Macro DMEM_RANGE_CHK_EN defined: addr >= DEPTH SHALL set err=1 in the ack cycle, suppress the write, and return rdata=16'hFFFF for reads.
REQ-029 Macro DMEM_RANGE_CHK_EN undefined: err SHALL be tied 0 and addr SHALL wrap modulo DEPTH for reads and writes.

Verification
REQ-030 Reset then write addr=0x0010 wdata=0xBEEF, WAIT_CYCLES=2 -> ack high exactly 3 cycles after req accepted, busy high 3 cycles; read 0x0010 -> rdata=0xBEEF in ack cycle.
REQ-031 WAIT_CYCLES=0, back-to-back write 0x0001=0x1234 then read 0x0001 with req held -> acks 2 cycles apart, read returns 0x1234.
REQ-032 Change addr/wdata/we during WAIT of a write to 0x0005=0xAAAA -> 0x0005 reads 0xAAAA, new address unchanged.
REQ-033 Assert reset in WAIT of a write 0x0007=0x5555 over prior 0x0007=0x1111 -> no ack, outputs reset values, 0x0007 reads 0x1111.
REQ-034 DEPTH=256, write 0x0100=0x7777 -> with DMEM_RANGE_CHK_EN err=1, read 0x0100 gives 0xFFFF, 0x0000 unchanged; without it err=0, 0x0000 reads 0x7777.
REQ-035 Drop req in WAIT of read 0x0010 -> ack still pulses once with rdata=0xBEEF, FSM returns to IDLE, no second ack.
